// File: rtl/fir_serial_mac.sv
// Serial multiply-accumulate FIR stage: sequences the tap counter and the delay-pipeline shift
// strobe, accumulates one product per tap, then rounds and saturates to one 16-bit output.
module fir_serial_mac #(
  parameter int unsigned NUM_TAPS   = 64,
  parameter int unsigned CNT_W      = 6,
  parameter int unsigned COEFF_FRAC = 15,
  parameter int unsigned ACC_W      = 40
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_valid_i,
  output logic                    ready_o,
  output logic                    phase_0_o,
  output logic [CNT_W-1:0]        current_count_o,
  input  logic signed [15:0]      tap_data_i,
  input  logic signed [15:0]      coeff_i,
  output logic signed [15:0]      filter_out_o,
  output logic                    out_valid_o,
  output logic                    overrun_o
);

  typedef enum logic [2:0] {StIdle, StShift, StRun, StFlush, StOutput} state_e;

  localparam logic [CNT_W-1:0]        LastTap = CNT_W'(NUM_TAPS - 1);
  localparam logic signed [ACC_W-1:0] RoundC  = ACC_W'(64'sd1 <<< (COEFF_FRAC - 1));
  localparam logic signed [ACC_W-1:0] SatMax  = ACC_W'(64'sd32767);
  localparam logic signed [ACC_W-1:0] SatMin  = ACC_W'(-64'sd32768);

  state_e                   state_q, state_d;
  logic                     phase_0_q, phase_0_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [31:0]       prod_q, prod_d;
  logic                     prod_valid_q, prod_valid_d;
  logic signed [15:0]       filter_q, filter_d;
  logic                     out_valid_q, out_valid_d;
  logic                     overrun_q, overrun_d;

  logic signed [ACC_W-1:0]  rnd_sum;
  logic signed [ACC_W-1:0]  rnd;
  logic signed [15:0]       sat;

  // Round half up, then clamp; saturation only ever happens here, never in the accumulator.
  always_comb begin
    rnd_sum = acc_q + RoundC;
    rnd     = rnd_sum >>> COEFF_FRAC;
    if (rnd > SatMax) begin
      sat = 16'sh7fff;
    end else if (rnd < SatMin) begin
      sat = 16'sh8000;
    end else begin
      sat = rnd[15:0];
    end
  end

  always_comb begin
    state_d      = state_q;
    phase_0_d    = 1'b0;
    count_d      = count_q;
    acc_d        = acc_q;
    prod_d       = prod_q;
    prod_valid_d = prod_valid_q;
    filter_d     = filter_q;
    out_valid_d  = 1'b0;
    overrun_d    = overrun_q;

    if (prod_valid_q) begin
      acc_d = acc_q + {{(ACC_W-32){prod_q[31]}}, prod_q};
    end
    if (sample_valid_i && (state_q != StIdle)) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (sample_valid_i) begin
          state_d   = StShift;
          phase_0_d = 1'b1;
        end
      end
      StShift: begin
        state_d = StRun;
        count_d = '0;
        acc_d   = '0;
      end
      StRun: begin
        prod_d       = 32'(tap_data_i) * 32'(coeff_i);
        prod_valid_d = 1'b1;
        if (count_q == LastTap) begin
          count_d = '0;
          state_d = StFlush;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      StFlush: begin
        prod_valid_d = 1'b0;
        state_d      = StOutput;
      end
      StOutput: begin
        filter_d    = sat;
        out_valid_d = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      phase_0_q    <= 1'b0;
      count_q      <= '0;
      acc_q        <= '0;
      prod_q       <= '0;
      prod_valid_q <= 1'b0;
      filter_q     <= '0;
      out_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_0_q    <= phase_0_d;
      count_q      <= count_d;
      acc_q        <= acc_d;
      prod_q       <= prod_d;
      prod_valid_q <= prod_valid_d;
      filter_q     <= filter_d;
      out_valid_q  <= out_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign ready_o         = (state_q == StIdle);
  assign phase_0_o       = phase_0_q;
  assign current_count_o = count_q;
  assign filter_out_o    = filter_q;
  assign out_valid_o     = out_valid_q;
  assign overrun_o       = overrun_q;

endmodule

// File: tb/tb_fir_serial_mac.sv
// Directed + randomized bench for fir_serial_mac; tap and coefficient banks are modelled as
// arrays indexed by current_count, and results come from a plain dot-product reference.
module tb_fir_serial_mac;

  localparam int NTaps = 64;

  logic               clk = 1'b0;
  logic               rst;
  logic               sample_valid;
  logic               ready;
  logic               phase_0;
  logic [5:0]         current_count;
  logic signed [15:0] tap_data;
  logic signed [15:0] coeff;
  logic signed [15:0] filter_out;
  logic               out_valid;
  logic               overrun;

  logic signed [15:0] taps   [NTaps];
  logic signed [15:0] coeffs [NTaps];

  int tests = 0;
  int fails = 0;
  bit exp_overrun = 1'b0;

  always #5 clk = ~clk;

  assign tap_data = taps[current_count];
  assign coeff    = coeffs[current_count];

  fir_serial_mac dut (
    .clk             (clk),
    .rst             (rst),
    .sample_valid_i  (sample_valid),
    .ready_o         (ready),
    .phase_0_o       (phase_0),
    .current_count_o (current_count),
    .tap_data_i      (tap_data),
    .coeff_i         (coeff),
    .filter_out_o    (filter_out),
    .out_valid_o     (out_valid),
    .overrun_o       (overrun)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint model();
    longint acc = 0;
    for (int i = 0; i < NTaps; i++) acc += longint'(taps[i]) * longint'(coeffs[i]);
    acc = (acc + 16384) >>> 15;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return acc;
  endfunction

  task automatic fill(input int tv, input int cv);
    for (int i = 0; i < NTaps; i++) begin
      taps[i]   = 16'(tv);
      coeffs[i] = 16'(cv);
    end
  endtask

  // Presents one sample; the edge taken here is E0.
  task automatic start(input string tag);
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    chk({tag, ".phase0_e0"}, phase_0, 1);
    chk({tag, ".ready_e0"}, ready, 0);
  endtask

  // Runs E1..E68; optional ignored pulse at edge extra_at, optional back-to-back accept at E68.
  task automatic finish(input string tag, input int extra_at, input bit b2b);
    longint exp = model();
    for (int k = 1; k <= 66; k++) begin
      if (extra_at == k) sample_valid = 1'b1;
      step();
      sample_valid = 1'b0;
      if (extra_at == k) begin
        exp_overrun = 1'b1;
        chk({tag, ".ignored_phase0"}, phase_0, 0);
      end
      if (k == 1) chk({tag, ".phase0_e1"}, phase_0, 0);
      chk({tag, ".count"}, current_count, (k <= 64) ? k - 1 : 0);
      chk({tag, ".out_valid_low"}, out_valid, 0);
      chk({tag, ".ready_low"}, ready, 0);
    end
    step();
    chk({tag, ".out_valid_e67"}, out_valid, 1);
    chk({tag, ".ready_e67"}, ready, 1);
    chk({tag, ".filter_out"}, filter_out, exp);
    chk({tag, ".overrun"}, overrun, exp_overrun);
    if (b2b) sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    chk({tag, ".out_valid_e68"}, out_valid, 0);
    chk({tag, ".phase0_e68"}, phase_0, b2b);
    chk({tag, ".filter_hold"}, filter_out, exp);
  endtask

  initial begin
    rst = 1'b1;
    sample_valid = 1'b0;
    fill(0, 0);
    step();
    step();
    chk("reset.ready", ready, 1);
    chk("reset.phase0", phase_0, 0);
    chk("reset.count", current_count, 0);
    chk("reset.filter", filter_out, 0);
    chk("reset.out_valid", out_valid, 0);
    chk("reset.overrun", overrun, 0);
    rst = 1'b0;
    step();

    // Impulse on tap 0: (32767000 + 16384) >>> 15 = 1000.
    fill(0, 0);
    taps[0] = 16'sd1000;
    coeffs[0] = 16'sd32767;
    start("impulse");
    finish("impulse", 0, 0);
    chk("impulse.const", filter_out, 1000);

    fill(32767, 32767);
    start("sat_pos");
    finish("sat_pos", 0, 0);
    chk("sat_pos.const", filter_out, 32767);

    fill(-32768, 32767);
    start("sat_neg");
    finish("sat_neg", 0, 0);
    chk("sat_neg.const", filter_out, -32768);

    // -3 * 0.5 rounds half up to -1.
    fill(0, 0);
    taps[5] = -16'sd3;
    coeffs[5] = 16'sd16384;
    start("round");
    finish("round", 0, 0);
    chk("round.const", filter_out, -1);

    // Ignored pulse at E10, then back-to-back accept in the out_valid cycle.
    fill(0, 0);
    taps[63] = 16'sd20000;
    coeffs[63] = -16'sd16384;
    start("overrun");
    finish("overrun", 10, 1);
    for (int i = 0; i < NTaps; i++) begin
      taps[i]   = 16'(int'($urandom_range(0, 4095)) - 2048);
      coeffs[i] = 16'(int'($urandom_range(0, 4095)) - 2048);
    end
    finish("b2b", 0, 0);

    // Reset mid-run discards the partial result.
    fill(1000, 1000);
    start("midrst");
    for (int k = 1; k < 30; k++) step();
    rst = 1'b1;
    #1;
    exp_overrun = 1'b0;
    chk("midrst.phase0", phase_0, 0);
    chk("midrst.count", current_count, 0);
    chk("midrst.filter", filter_out, 0);
    chk("midrst.out_valid", out_valid, 0);
    chk("midrst.overrun", overrun, 0);
    chk("midrst.ready", ready, 1);
    step();
    step();
    rst = 1'b0;
    for (int k = 0; k < 70; k++) begin
      step();
      chk("midrst.no_out_valid", out_valid, 0);
    end
    fill(0, 0);
    taps[7] = 16'sd12345;
    coeffs[7] = 16'sd8192;
    start("post_rst");
    finish("post_rst", 0, 0);

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < NTaps; i++) begin
        taps[i] = 16'($urandom);
        coeffs[i] = (t < 3) ? 16'(int'($urandom_range(0, 1023)) - 512) : 16'($urandom);
      end
      start("random");
      finish("random", 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
